// File: rtl/jt51_timer_pkg.sv
// jt51_timer_pkg
// Shared constants for the YM2151 timer register front end.
//   - Register addresses of the timer pair (clock A high/low, clock B, control).
//   - Bit positions inside the control register (reg 0x14).
package jt51_timer_pkg;

    localparam logic [7:0] REG_CLKA1 = 8'h10;   // timer A value, bits [9:2]
    localparam logic [7:0] REG_CLKA2 = 8'h11;   // timer A value, bits [1:0]
    localparam logic [7:0] REG_CLKB  = 8'h12;   // timer B value
    localparam logic [7:0] REG_CTRL  = 8'h14;   // load / irq enable / flag clear / CSM

    localparam int CTRL_LOAD_A  = 0;
    localparam int CTRL_LOAD_B  = 1;
    localparam int CTRL_IRQEN_A = 2;
    localparam int CTRL_IRQEN_B = 3;
    localparam int CTRL_CLR_A   = 4;
    localparam int CTRL_CLR_B   = 5;
    localparam int CTRL_CSM     = 7;

endpackage

// File: rtl/jt51_timer_busy.sv
// jt51_timer_busy
// Loadable down counter producing the status busy bit.
//   clk    : system clock
//   rst_n  : synchronous reset, active low (clears the counter, ends busy at once)
//   cen    : chip clock enable; the counter steps down once per cen while nonzero
//   load   : reload to BUSY_CYC; takes priority over a coincident cen
//   busy   : high while the counter is nonzero
module jt51_timer_busy #(
    parameter int unsigned BUSY_CYC = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic load,
    output logic busy
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (load) begin
            cnt_reg <= 8'(BUSY_CYC);
        end else if (cen && (cnt_reg != 8'd0)) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign busy = (cnt_reg != 8'd0);

endmodule

// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl
// CPU-side register front end for the YM2151 timer pair.
// Decodes address/data writes to regs 0x10/0x11/0x12/0x14, drives the timer
// datapath controls, provides the status byte and the CSM key-on request.
//
// Build option: define JT51_TIMER_CSM_EN to store reg14 bit7 (CSM) and
// generate csm_keyon on rising overflow_A; otherwise csm_keyon is tied 0.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   cen                 : chip clock enable (busy counter timebase)
//   cs_n, wr_n, a0, din : CPU bus; a write event is the first clk with
//                         cs_n=0 and wr_n low after being high
//   flag_A, flag_B      : timer flags (status bits 0/1)
//   overflow_A          : timer A overflow pulse (CSM source)
//   dout                : status {busy,5'b0,flag_B,flag_A}
//   value_A, value_B    : timer start values
//   load_A/B, enable_irq_A/B : control levels from reg14[3:0]
//   clr_flag_A/B        : one-clk flag clear pulses
//   csm_keyon           : one-clk all-slot key-on request
module jt51_timer_ctrl
    import jt51_timer_pkg::*;
#(
    parameter int unsigned BUSY_CYC = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [7:0] dout,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm_keyon
);

    logic       wr_prev_reg;
    logic [7:0] addr_reg;
    logic [7:0] reg10_reg;
    logic [1:0] reg11_reg;
    logic [7:0] reg12_reg;
    logic [3:0] ctrl_reg;
    logic       clr_a_reg;
    logic       clr_b_reg;
    logic       wr_event;
    logic       data_wr;
    logic       busy;

    // Falling edge of the level-sampled strobe: a held strobe counts once.
    assign wr_event = !cs_n && !wr_n && wr_prev_reg;
    assign data_wr  = wr_event && a0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_prev_reg <= 1'b1;
            addr_reg    <= 8'd0;
            reg10_reg   <= 8'd0;
            reg11_reg   <= 2'd0;
            reg12_reg   <= 8'd0;
            ctrl_reg    <= 4'd0;
            clr_a_reg   <= 1'b0;
            clr_b_reg   <= 1'b0;
        end else begin
            wr_prev_reg <= wr_n;
            clr_a_reg   <= 1'b0;
            clr_b_reg   <= 1'b0;
            if (wr_event) begin
                if (!a0) begin
                    addr_reg <= din;
                end else begin
                    case (addr_reg)
                        REG_CLKA1: reg10_reg <= din;
                        REG_CLKA2: reg11_reg <= din[1:0];
                        REG_CLKB:  reg12_reg <= din;
                        REG_CTRL: begin
                            ctrl_reg  <= din[3:0];
                            clr_a_reg <= din[CTRL_CLR_A];
                            clr_b_reg <= din[CTRL_CLR_B];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    jt51_timer_busy #(
        .BUSY_CYC (BUSY_CYC)
    ) u_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .load  (data_wr),
        .busy  (busy)
    );

`ifdef JT51_TIMER_CSM_EN
    logic csm_reg;
    logic ovf_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csm_reg      <= 1'b0;
            ovf_prev_reg <= 1'b0;
        end else begin
            ovf_prev_reg <= overflow_A;
            if (data_wr && (addr_reg == REG_CTRL)) begin
                csm_reg <= din[CTRL_CSM];
            end
        end
    end

    // Rising edge of overflow_A so a level held for several clks keys on once.
    assign csm_keyon = overflow_A && csm_reg && !ovf_prev_reg;
`else
    logic unused_overflow;
    assign unused_overflow = overflow_A;
    assign csm_keyon       = 1'b0;
`endif

    assign dout         = {busy, 5'b00000, flag_B, flag_A};
    assign value_A      = {reg10_reg, reg11_reg};
    assign value_B      = reg12_reg;
    assign load_A       = ctrl_reg[CTRL_LOAD_A];
    assign load_B       = ctrl_reg[CTRL_LOAD_B];
    assign enable_irq_A = ctrl_reg[CTRL_IRQEN_A];
    assign enable_irq_B = ctrl_reg[CTRL_IRQEN_B];
    assign clr_flag_A   = clr_a_reg;
    assign clr_flag_B   = clr_b_reg;

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
module tb_jt51_timer_ctrl;

    localparam int BUSY = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic       overflow_A = 1'b0;
    logic [7:0] dout;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, enable_irq_A, enable_irq_B;
    logic       clr_flag_A, clr_flag_B, csm_keyon;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit cen_rand = 1'b0;

    jt51_timer_ctrl #(.BUSY_CYC(BUSY)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0),
        .din(din), .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
        .dout(dout), .value_A(value_A), .value_B(value_B), .load_A(load_A),
        .load_B(load_B), .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .csm_keyon(csm_keyon)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The register file is a plain byte-per-address map; outputs are derived
    // from it by reading the documented bit fields.
    logic [7:0] m_regs [256];
    logic [7:0] m_addr;
    int         m_busy;
    bit         m_clr_a, m_clr_b, m_wr_prev, m_ovf_prev;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_regs[i] <= 8'd0;
            m_addr <= 8'd0; m_busy <= 0; m_clr_a <= 0; m_clr_b <= 0;
            m_wr_prev <= 1'b1; m_ovf_prev <= 1'b0;
        end else begin
            m_wr_prev  <= wr_n;
            m_ovf_prev <= overflow_A;
            m_clr_a <= 0; m_clr_b <= 0;
            if (!cs_n && !wr_n && m_wr_prev) begin
                if (!a0) m_addr <= din;
                else begin
                    m_regs[m_addr] <= din;
                    m_busy <= BUSY;
                    if (m_addr == 8'h14) begin
                        m_clr_a <= din[4];
                        m_clr_b <= din[5];
                    end
                end
            end else if (cen && m_busy > 0) begin
                m_busy <= m_busy - 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [7:0] r14;
            bit exp_key;
            r14 = m_regs[8'h14];
`ifdef JT51_TIMER_CSM_EN
            exp_key = overflow_A && r14[7] && !m_ovf_prev;
`else
            exp_key = 1'b0;
`endif
            check("m_dout", dout, {(m_busy != 0), 5'b0, flag_B, flag_A});
            check("m_value_A", value_A, {m_regs[8'h10], m_regs[8'h11][1:0]});
            check("m_value_B", value_B, m_regs[8'h12]);
            check("m_ctrl", {enable_irq_B, enable_irq_A, load_B, load_A}, r14[3:0]);
            check("m_clr", {clr_flag_B, clr_flag_A}, {m_clr_b, m_clr_a});
            check("m_csm_keyon", csm_keyon, exp_key);
        end
    end

    // cen: every 4th clk, or random during the random phase.
    initial begin
        int div = 0;
        forever begin
            @(posedge clk); #1;
            div = (div + 1) % 4;
            cen = cen_rand ? ($urandom_range(0, 2) == 0) : (div == 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input bit is_data, input logic [7:0] d);
        cs_n = 0; a0 = is_data; din = d; wr_n = 0;
        tick();
        wr_n = 1; cs_n = 1;
        tick();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (dout[7] && g < 1000) begin tick(); g++; end
        check("wait_idle_timeout", dout[7], 0);
    endtask

    initial begin
        int n;
        int g;
        int key_cnt;
        bit second_done;

        // 1. reset
        rst_n = 0;
        tick(); tick();
        chk_en = 1;
        check("reset_dout", dout, 8'h00);
        check("reset_value_A", value_A, 0);
        check("reset_outs", {value_B, load_A, load_B, enable_irq_A, enable_irq_B,
                             clr_flag_A, clr_flag_B, csm_keyon}, 0);
        rst_n = 1;
        tick(); tick();
        check("post_reset_hold", {dout, value_A, value_B}, 0);

        // 2. timer values
        bus_write(0, 8'h10); bus_write(1, 8'hA5);
        bus_write(0, 8'h11); bus_write(1, 8'h03);
        check("value_A_297", value_A, 10'h297);
        bus_write(0, 8'h12); bus_write(1, 8'h7E);
        check("value_B_7E", value_B, 8'h7E);

        // 3. control register and clear pulses
        bus_write(0, 8'h14);
        cs_n = 0; a0 = 1; din = 8'h3F; wr_n = 0;
        tick();
        check("clr_pulse_on", {clr_flag_B, clr_flag_A}, 2'b11);
        tick();
        check("clr_held_strobe_off", {clr_flag_B, clr_flag_A}, 2'b00);
        wr_n = 1; cs_n = 1;
        tick();
        check("ctrl_3F", {enable_irq_B, enable_irq_A, load_B, load_A}, 4'hF);
        check("clr_pulse_off", {clr_flag_B, clr_flag_A}, 2'b00);

        // 4. busy timing
        wait_idle();
        bus_write(0, 8'h20);
        check("addr_write_no_busy", dout[7], 0);
        tick(); tick();
        check("addr_write_no_busy2", dout[7], 0);
        cs_n = 0; a0 = 1; din = 8'h00; wr_n = 0;
        tick();
        wr_n = 1; cs_n = 1;
        check("busy_start", dout[7], 1);
        n = 0; g = 0; second_done = 0;
        while (dout[7] && g < 2000) begin
            bit c;
            bit we;
            c = cen;
            we = (n == 10) && !second_done;
            if (we) begin cs_n = 0; a0 = 1; din = 8'h00; wr_n = 0; end
            tick();
            if (we) begin wr_n = 1; cs_n = 1; second_done = 1; end
            else if (c) n++;
            g++;
        end
        check("busy_cen_total_42", n, 42);

        // 5. status flags
        flag_A = 1; flag_B = 1;
        tick();
        check("status_idle_03", dout, 8'h03);
        bus_write(1, 8'h00);
        check("status_busy_83", dout, 8'h83);
        flag_A = 0; flag_B = 0;

        // 6. CSM key-on
        bus_write(0, 8'h14); bus_write(1, 8'h81);
        key_cnt = 0;
        overflow_A = 1;
        for (int i = 0; i < 3; i++) begin #2; key_cnt += csm_keyon; tick(); end
        overflow_A = 0;
        tick();
`ifdef JT51_TIMER_CSM_EN
        check("csm_one_pulse", key_cnt, 1);
`else
        check("csm_disabled_none", key_cnt, 0);
`endif
        bus_write(1, 8'h01);
        key_cnt = 0;
        overflow_A = 1;
        for (int i = 0; i < 3; i++) begin #2; key_cnt += csm_keyon; tick(); end
        overflow_A = 0;
        tick();
        check("csm_off_none", key_cnt, 0);

        // Random phase against the model.
        cen_rand = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            cs_n   = ($urandom_range(0, 3) == 0);
            wr_n   = $urandom_range(0, 1);
            a0     = $urandom_range(0, 1);
            if (!a0) begin
                case ($urandom_range(0, 4))
                    0: din = 8'h10;
                    1: din = 8'h11;
                    2: din = 8'h12;
                    3: din = 8'h14;
                    default: din = 8'($urandom);
                endcase
            end else begin
                din = 8'($urandom);
            end
            flag_A = $urandom_range(0, 1);
            flag_B = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) overflow_A = ~overflow_A;
            tick();
        end
        rst_n = 1; cs_n = 1; wr_n = 1; overflow_A = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
